sd_rx_fifo: RTL and testbench

//  Receive-side word FIFO between the SD DAT receiver and the DMA/CPU read port.

---
 rtl/sd_rx_fifo_if.sv | 26 ++
 rtl/sd_rx_fifo.sv | 91 +++++++++
 tb/tb_sd_rx_fifo.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sd_rx_fifo_if.sv
// rtl/sd_rx_fifo_if.sv - push/pop/flush bundle between SD DAT receiver, DMA/CPU reader and the rx FIFO
interface sd_rx_fifo_if #(
    parameter int unsigned DEPTH_BITS = 8
);
    logic                  flush;
    logic                  push;
    logic [31:0]           push_data;
    logic                  full;
    logic                  almost_full;
    logic                  overrun;
    logic                  pop;
    logic [31:0]           pop_data;
    logic                  pop_valid;
    logic                  empty;
    logic [DEPTH_BITS:0]   count;

    modport master (
        output flush, push, push_data, pop,
        input  full, almost_full, overrun, pop_data, pop_valid, empty, count
    );

    modport slave (
        input  flush, push, push_data, pop,
        output full, almost_full, overrun, pop_data, pop_valid, empty, count
    );
endinterface

// File: rtl/sd_rx_fifo.sv
// rtl/sd_rx_fifo.sv - receive-side 32-bit word FIFO with sticky overrun and almost-full flow control
module sd_rx_fifo #(
    parameter int unsigned DEPTH_BITS         = 8,
    parameter int unsigned ALMOST_FULL_MARGIN = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    sd_rx_fifo_if.slave    bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_W  = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0] MARGIN_W = ALMOST_FULL_MARGIN[DEPTH_BITS:0];
    localparam logic [DEPTH_BITS:0] ONE_W    = {{DEPTH_BITS{1'b0}}, 1'b1};

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count_q;
    logic [DEPTH_BITS:0]   count_next;
    logic [DEPTH_BITS:0]   free_next;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  overrun_q;
    logic                  pop_valid_q;
    logic [31:0]           pop_data_q;
    logic                  empty_q;
    logic                  full_q;
    logic                  almost_full_q;

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok     = bus.pop && !bus.flush && (count_q != '0);
        push_ok    = bus.push && !bus.flush && ((count_q != DEPTH_W) || pop_ok);
        count_next = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_q + ONE_W;
            2'b01:   count_next = count_q - ONE_W;
            default: count_next = count_q;
        endcase
        free_next  = DEPTH_W - count_next;
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.push_data;
        end
    end

    // Flush leaves the last popped word visible; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pop_data_q <= '0;
        end else if (pop_ok) begin
            pop_data_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
            pop_valid_q   <= 1'b0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q       <= count_next;
            overrun_q     <= overrun_q || (bus.push && !push_ok);
            pop_valid_q   <= pop_ok;
            empty_q       <= (count_next == '0);
            full_q        <= (count_next == DEPTH_W);
            almost_full_q <= (free_next <= MARGIN_W);
        end
    end

    assign bus.count       = count_q;
    assign bus.overrun     = overrun_q;
    assign bus.pop_valid   = pop_valid_q;
    assign bus.pop_data    = pop_data_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
endmodule

// File: tb/tb_sd_rx_fifo.sv
// tb/tb_sd_rx_fifo.sv - directed and randomized checks of sd_rx_fifo against a queue model
module tb_sd_rx_fifo;
    localparam int DB     = 8;
    localparam int DEPTH  = 256;
    localparam int MARGIN = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] model_q [$];
    logic        m_ovr;
    logic        m_valid;
    logic [31:0] m_data;

    sd_rx_fifo_if #(.DEPTH_BITS(DB)) bus();

    sd_rx_fifo #(.DEPTH_BITS(DB), .ALMOST_FULL_MARGIN(MARGIN)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"},       32'(bus.count), 32'(sz));
        check({tag, ".empty"},       32'(bus.empty), 32'(sz == 0));
        check({tag, ".full"},        32'(bus.full), 32'(sz == DEPTH));
        check({tag, ".almost_full"}, 32'(bus.almost_full), 32'((DEPTH - sz) <= MARGIN));
        check({tag, ".overrun"},     32'(bus.overrun), 32'(m_ovr));
        check({tag, ".pop_valid"},   32'(bus.pop_valid), 32'(m_valid));
        check({tag, ".pop_data"},    bus.pop_data, m_data);
    endtask

    // One clock of stimulus; the model is updated from the FIFO rules, then every output is compared.
    task automatic step(input string tag, input logic push, input logic [31:0] data,
                        input logic pop, input logic flush);
        logic pop_acc;
        logic push_acc;
        bus.push      = push;
        bus.push_data = data;
        bus.pop       = pop;
        bus.flush     = flush;
        @(posedge clk);
        #1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
        if (flush) begin
            model_q.delete();
            m_ovr   = 1'b0;
            m_valid = 1'b0;
        end else begin
            pop_acc  = pop && (model_q.size() > 0);
            push_acc = push && ((model_q.size() < DEPTH) || pop_acc);
            m_valid  = pop_acc;
            if (pop_acc) m_data = model_q.pop_front();
            if (push_acc) model_q.push_back(data);
            else if (push) m_ovr = 1'b1;
        end
        check_all(tag);
    endtask

    initial begin
        int pushed;
        int cycles;
        logic do_push;
        logic do_pop;

        reset         = 1'b1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.flush     = 1'b0;
        bus.push_data = '0;
        m_ovr   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        for (int i = 1; i <= 4; i++) step("basic_push", 1'b1, 32'h1111_1111 * i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)  step("basic_pop", 1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 32'(i), 1'b0, 1'b0);
        step("overflow_push", 1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain_after_ovr", 1'b0, 32'h0, 1'b1, 1'b0);
        step("pop_empty", 1'b0, 32'h0, 1'b1, 1'b0);

        step("flush_clear", 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, $urandom, 1'b0, 1'b0);
        step("full_push_pop", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain_full", 1'b0, 32'h0, 1'b1, 1'b0);
        check("last_word_deadbeef", m_data, 32'hDEAD_BEEF);

        step("pop_empty_push", 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
        step("pop_a5", 1'b0, 32'h0, 1'b1, 1'b0);

        pushed = 0;
        cycles = 0;
        while (pushed < 300 && cycles < 3000) begin
            do_push = (model_q.size() < 8) && ($urandom_range(3) != 0);
            do_pop  = ($urandom_range(3) != 0);
            if (do_push) pushed++;
            step("stream", do_push, $urandom, do_pop, 1'b0);
            cycles++;
        end
        check("stream_done", 32'(pushed >= 300), 32'd1);
        while (model_q.size() > 0) step("stream_drain", 1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) step("pre_flush", 1'b1, $urandom, 1'b0, 1'b0);
        step("pre_flush_pop", 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("pre_flush_fill", 1'b1, $urandom, 1'b0, 1'b0);
        step("flush_mid", 1'b1, $urandom, 1'b1, 1'b1);
        step("after_flush_push", 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        step("after_flush_pop", 1'b0, 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
